// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM state type, the reset PC default and the PC increment.
package cpu_pkg;

    localparam int XLEN = 32;

    // Fetch FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;

    // Sequential PC; wraps naturally at 32 bits (32'hFFFF_FFFC -> 0).
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction and its PC while decode stalls.
// Clear has priority over load; unload empties the entry.
module fetch_skid
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            unload_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] data_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o
);

    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;

    // Capture on load, drop on clear or unload.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory request, forwards
// fetched instructions to decode, absorbs decode stalls with a one-entry skid
// buffer and handles execute redirects (draining any outstanding request).
// Optional feature macro: FETCH_PERF_CNT_EN adds the stall_cycles counter.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        StallD,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] stall_cycles,
`endif
    output logic        ValidD
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pcd_q, pcd_d;
    logic         valid_q, valid_d;
    logic [31:0]  drain_addr_q, drain_addr_d;

    logic         skid_load, skid_unload, skid_clear;
    logic [31:0]  skid_data, skid_pc;
    logic         skid_valid;
    logic         slot_free;

    fetch_skid u_skid (
        .clk      (clk),
        .reset    (reset),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .data_i   (imem_rdata),
        .pc_i     (pc_q),
        .data_o   (skid_data),
        .pc_o     (skid_pc),
        .valid_o  (skid_valid)
    );

    // Decode can take a new instruction when it is empty or not stalled.
    assign slot_free = !valid_q || !StallD;

    // Request goes out in FETCH and DRAIN; DRAIN keeps the pre-redirect address
    // so the address stays stable until the outstanding access completes.
    always_comb begin
        imem_req  = (state_q == FETCH) || (state_q == DRAIN);
        imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    end

    // Next-state logic for the FSM, PC, decode outputs and skid control.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pcd_d        = pcd_q;
        valid_d      = valid_q;
        drain_addr_d = drain_addr_q;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_clear   = 1'b0;

        // Decode consumed the current instruction; refilled below if data arrives.
        if (valid_q && !StallD) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    pc_d = next_pc(pc_q);
                    if (slot_free) begin
                        instr_d = imem_rdata;
                        pcd_d   = pc_q;
                        valid_d = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!StallD) begin
                    if (skid_valid) begin
                        instr_d = skid_data;
                        pcd_d   = skid_pc;
                        valid_d = 1'b1;
                    end
                    skid_unload = 1'b1;
                    state_d     = FETCH;
                end
            end
            DRAIN: begin
                // The stale response is dropped; resume at the redirected PC.
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A redirect overrides stalls and any fetch result this cycle. If the
        // memory still owes us a response, wait for it in DRAIN; an ack that
        // lands in DRAIN together with a new redirect completes the drain.
        if (BranchTakenE) begin
            pc_d        = BranchTargetE;
            instr_d     = instr_q;
            pcd_d       = pcd_q;
            valid_d     = 1'b0;
            skid_load   = 1'b0;
            skid_unload = 1'b0;
            skid_clear  = 1'b1;
            if (state_q == FETCH && !imem_ack) begin
                drain_addr_d = pc_q;
                state_d      = DRAIN;
            end else if (state_q == DRAIN && !imem_ack) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            pcd_q        <= '0;
            valid_q      <= 1'b0;
            drain_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            valid_q      <= valid_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    assign InstrD = instr_q;
    assign PCD    = pcd_q;
    assign ValidD = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count cycles spent in HOLD or DRAIN, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if ((state_q == HOLD || state_q == DRAIN) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 imem_req  output  1  instruction memory request; held high until imem_ack.
REQ-005 imem_addr  output  32  word address of request (= PC); stable while imem_req high.
REQ-006 imem_ack  input  1  request completed this cycle; imem_rdata valid.
REQ-007 imem_rdata  input  32  fetched instruction.
REQ-008 StallD  input  1  decode cannot accept; InstrD/PCD/ValidD SHALL hold.
REQ-009 BranchTakenE  input  1  redirect request from execute.
REQ-010 BranchTargetE  input  32  redirect PC.
REQ-011 InstrD  output  32  instruction to decode (feeds the immediate extender and decoder).
REQ-012 PCD  output  32  address of InstrD.
REQ-013 ValidD  output  1  InstrD holds a live instruction.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, HOLD, DRAIN; 2-bit encoding.
REQ-015 IDLE: imem_req=0; next state FETCH unconditionally.
REQ-016 FETCH: imem_req=1, imem_addr=PC; on imem_ack without redirect, PC SHALL advance by 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-017 Output slot free = !ValidD or !StallD; on ack with free slot, imem_rdata/PC SHALL load InstrD/PCD, ValidD=1, stay FETCH.
REQ-018 On ack with slot occupied and StallD=1, data SHALL load the one-entry skid buffer; next state HOLD.
REQ-019 HOLD: imem_req=0; when StallD falls, skid SHALL move to InstrD/PCD next edge, ValidD=1; next state FETCH.
REQ-020 Without ack, ValidD SHALL clear when the current instruction is consumed (ValidD and !StallD).
REQ-021 Redirect (BranchTakenE=1) SHALL override StallD: ValidD, skid valid cleared; PC<=BranchTargetE.
REQ-022 Redirect in FETCH without same-cycle ack SHALL go DRAIN; in FETCH with same-cycle ack, HOLD or IDLE, SHALL go FETCH and discard returned data.
REQ-023 DRAIN: imem_req stays high at old address; data on ack SHALL be discarded; next state FETCH at redirected PC.
REQ-024 Redirect in DRAIN SHALL overwrite PC with newest target, remain DRAIN.
REQ-025 Fetch-to-decode latency SHALL be one cycle after imem_ack; zero-wait memory yields one instruction per cycle.
REQ-026 No instruction SHALL be duplicated or dropped except those flushed by redirect.

Reset
REQ-027 Reset SHALL force: state IDLE, PC=RESET_PC, imem_req=0, ValidD=0, InstrD=0, PCD=0, skid empty, counter 0.
REQ-028 Reset mid-request SHALL abandon it; memory ack arriving later is ignored (state IDLE).

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined: output stall_cycles (32-bit) SHALL count cycles with state HOLD or DRAIN, saturating at 32'hFFFF_FFFF.
REQ-030 Macro undefined: stall_cycles port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package cpu_pkg SHALL hold fetch_state_t enum, RESET_PC default, and PC_INC constant (4).
REQ-032 Skid buffer SHALL be sub-module fetch_skid (data+PC+valid, load/unload/clear).

Verification
REQ-033 Reset, RESET_PC=0, ack every cycle, rdata=addr^32'hA5A5_0000 -> ValidD from cycle 3; PCD 0,4,8 consecutive; InstrD matches.
REQ-034 StallD high 3 cycles while ack arrives -> HOLD entered, imem_req=0, InstrD unchanged; release -> skid instruction next, no loss.
REQ-035 Redirect to 32'h100 while request outstanding (ack delayed 2 cycles) -> DRAIN, stale data discarded, next imem_addr=32'h100, ValidD=0 meanwhile.
REQ-036 Redirect with StallD=1 and skid full -> ValidD=0, skid cleared, PC=target next cycle.
REQ-037 PC=32'hFFFF_FFFC fetch -> next imem_addr=0.
REQ-038 Reset asserted during FETCH with ack 1 cycle later -> ack ignored, ValidD=0, imem_addr=RESET_PC after IDLE; with FETCH_PERF_CNT_EN, stall_cycles=0.
